dual_port_ram_bank: RTL and testbench

- Parametrised true dual-port synchronous RAM; successor to the fixed 16x8 dual-port RAM used in the layered-testbench environment.
- Adds configurable data width, depth and read latency, plus per-byte write enables.
- Adds read-valid strobes, hardware memory clear after reset, and defined cross-port collision handling with a collision counter.
- Sits between two independent requesters (port A, port B) that share one clock.

---
 rtl/dual_port_ram_bank.sv | 269 ++++++++++++++++++++++++++
 tb/tb_dual_port_ram_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_bank.sv
// dual_port_ram_bank
//   True dual-port synchronous RAM with two independent requesters sharing
//   one clock. Per-byte write enables, read-valid strobes, a hardware clear
//   of the whole array after reset, and a saturating counter of same-address
//   write-write collisions.
//
// Parameters
//   DATA_W     data width, multiple of 8 (NB = DATA_W/8 byte lanes)
//   ADDR_W     address width, DEPTH = 2**ADDR_W words
//   RD_LATENCY 1 or 2 cycles from read request edge to rvalid
//   CNT_W      width of the saturating collision counter
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   en_x/we_x/be_x/addr_x/wdata_x  request on port x (a or b)
//   rdata_x/rvalid_x            read data, valid for one cycle per read
//   init_done                   high once the post-reset clear has finished
//   coll_cnt/coll_clr           collision count and its synchronous clear
//   perr_a/perr_b               per-lane parity error, only with DPRAM_PARITY_EN
//
// Build option
//   `define DPRAM_PARITY_EN adds one even-parity bit per stored byte and the
//   perr_a/perr_b outputs.

module dual_port_ram_bank #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [DATA_W/8-1:0]   be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     wdata_a,
  output logic [DATA_W-1:0]     rdata_a,
  output logic                  rvalid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     wdata_b,
  output logic [DATA_W-1:0]     rdata_b,
  output logic                  rvalid_b,
  output logic                  init_done,
  output logic [CNT_W-1:0]      coll_cnt,
  input  logic                  coll_clr
`ifdef DPRAM_PARITY_EN
  ,
  output logic [DATA_W/8-1:0]   perr_a,
  output logic [DATA_W/8-1:0]   perr_b
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  // ---------------------------------------------------------------------
  // Clear / ready FSM
  // ---------------------------------------------------------------------
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      S_CLEAR: begin
        clr_ptr_next = clr_ptr_reg + 1'b1;
        // Last word written this cycle: DEPTH clear cycles in total.
        if (&clr_ptr_reg) state_next = S_READY;
      end
      default: ;
    endcase
  end

  logic clearing;
  assign clearing  = (state_reg == S_CLEAR);
  assign init_done = (state_reg == S_READY);

  // Requests are only honoured once the clear has finished.
  logic wr_a, rd_a, wr_b, rd_b;
  assign wr_a = init_done & en_a &  we_a;
  assign rd_a = init_done & en_a & ~we_a;
  assign wr_b = init_done & en_b &  we_b;
  assign rd_b = init_done & en_b & ~we_b;

  // ---------------------------------------------------------------------
  // Storage, one array per byte lane
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] s1_data_a, s1_data_b;
  logic              v1_a_reg,  v1_b_reg;
`ifdef DPRAM_PARITY_EN
  logic [NB-1:0]     s1_perr_a, s1_perr_b;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_a_reg, rd_b_reg;

      // B is written first so that A's non-blocking update lands last and
      // wins on a same-address, same-lane collision.
      always_ff @(posedge clk) begin
        if (clearing) begin
          mem[clr_ptr_reg] <= 8'h00;
        end else begin
          if (wr_b && be_b[gi]) mem[addr_b] <= wdata_b[8*gi +: 8];
          if (wr_a && be_a[gi]) mem[addr_a] <= wdata_a[8*gi +: 8];
        end
      end

      // Reading the array on the same edge as the write yields the old
      // contents, which gives read-first behaviour across ports.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_a_reg <= '0;
          rd_b_reg <= '0;
        end else begin
          if (rd_a) rd_a_reg <= mem[addr_a];
          if (rd_b) rd_b_reg <= mem[addr_b];
        end
      end

      assign s1_data_a[8*gi +: 8] = rd_a_reg;
      assign s1_data_b[8*gi +: 8] = rd_b_reg;

`ifdef DPRAM_PARITY_EN
      logic par_mem [DEPTH];
      logic perr_a_reg, perr_b_reg;

      always_ff @(posedge clk) begin
        if (clearing) begin
          par_mem[clr_ptr_reg] <= 1'b0;
        end else begin
          if (wr_b && be_b[gi]) par_mem[addr_b] <= ^wdata_b[8*gi +: 8];
          if (wr_a && be_a[gi]) par_mem[addr_a] <= ^wdata_a[8*gi +: 8];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          perr_a_reg <= 1'b0;
          perr_b_reg <= 1'b0;
        end else begin
          if (rd_a) perr_a_reg <= (^mem[addr_a]) ^ par_mem[addr_a];
          if (rd_b) perr_b_reg <= (^mem[addr_b]) ^ par_mem[addr_b];
        end
      end

      assign s1_perr_a[gi] = perr_a_reg;
      assign s1_perr_b[gi] = perr_b_reg;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_a_reg <= 1'b0;
      v1_b_reg <= 1'b0;
    end else begin
      v1_a_reg <= rd_a;
      v1_b_reg <= rd_b;
    end
  end

  // ---------------------------------------------------------------------
  // Read latency: the first stage already holds its value between reads,
  // so latency 1 drives it straight out.
  // ---------------------------------------------------------------------
`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] perr_q_a, perr_q_b;
`endif

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] d2_a_reg, d2_b_reg;
      logic              v2_a_reg, v2_b_reg;
`ifdef DPRAM_PARITY_EN
      logic [NB-1:0]     p2_a_reg, p2_b_reg;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d2_a_reg <= '0;
          d2_b_reg <= '0;
          v2_a_reg <= 1'b0;
          v2_b_reg <= 1'b0;
`ifdef DPRAM_PARITY_EN
          p2_a_reg <= '0;
          p2_b_reg <= '0;
`endif
        end else begin
          v2_a_reg <= v1_a_reg;
          v2_b_reg <= v1_b_reg;
          if (v1_a_reg) d2_a_reg <= s1_data_a;
          if (v1_b_reg) d2_b_reg <= s1_data_b;
`ifdef DPRAM_PARITY_EN
          if (v1_a_reg) p2_a_reg <= s1_perr_a;
          if (v1_b_reg) p2_b_reg <= s1_perr_b;
`endif
        end
      end

      assign rdata_a  = d2_a_reg;
      assign rdata_b  = d2_b_reg;
      assign rvalid_a = v2_a_reg;
      assign rvalid_b = v2_b_reg;
`ifdef DPRAM_PARITY_EN
      assign perr_q_a = p2_a_reg;
      assign perr_q_b = p2_b_reg;
`endif
    end else begin : g_lat1
      assign rdata_a  = s1_data_a;
      assign rdata_b  = s1_data_b;
      assign rvalid_a = v1_a_reg;
      assign rvalid_b = v1_b_reg;
`ifdef DPRAM_PARITY_EN
      assign perr_q_a = s1_perr_a;
      assign perr_q_b = s1_perr_b;
`endif
    end
  endgenerate

`ifdef DPRAM_PARITY_EN
  // The held error flags are only meaningful alongside rvalid.
  assign perr_a = perr_q_a & {NB{rvalid_a}};
  assign perr_b = perr_q_b & {NB{rvalid_b}};
`endif

  // ---------------------------------------------------------------------
  // Write-write collision counter (clear beats a coincident collision)
  // ---------------------------------------------------------------------
  logic             coll_hit;
  logic [CNT_W-1:0] coll_cnt_reg;

  assign coll_hit = wr_a & wr_b & (addr_a == addr_b) & (|be_a) & (|be_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt_reg <= '0;
    end else if (coll_clr) begin
      coll_cnt_reg <= '0;
    end else if (coll_hit && (coll_cnt_reg != {CNT_W{1'b1}})) begin
      coll_cnt_reg <= coll_cnt_reg + 1'b1;
    end
  end

  assign coll_cnt = coll_cnt_reg;

endmodule

// File: tb/tb_dual_port_ram_bank.sv
module tb_dual_port_ram_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en_a, we_a, en_b, we_b, coll_clr;
  logic [NB-1:0]     be_a, be_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;

  logic [DATA_W-1:0] rdata_a, rdata_b, rdata2_a, rdata2_b;
  logic              rvalid_a, rvalid_b, rvalid2_a, rvalid2_b;
  logic              init_done, init_done2;
  logic [CNT_W-1:0]  coll_cnt, coll_cnt2;
`ifdef DPRAM_PARITY_EN
  logic [NB-1:0]     perr_a, perr_b, perr2_a, perr2_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_port_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .init_done(init_done), .coll_cnt(coll_cnt), .coll_clr(coll_clr)
`ifdef DPRAM_PARITY_EN
    , .perr_a(perr_a), .perr_b(perr_b)
`endif
  );

  dual_port_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LATENCY(2), .CNT_W(CNT_W)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata2_a), .rvalid_a(rvalid2_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata2_b), .rvalid_b(rvalid2_b),
    .init_done(init_done2), .coll_cnt(coll_cnt2), .coll_clr(coll_clr)
`ifdef DPRAM_PARITY_EN
    , .perr_a(perr2_a), .perr_b(perr2_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; wdata_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; wdata_b = '0;
    coll_clr = 1'b0;
  endtask

  task automatic wr_port_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    en_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = d; be_a = be;
  endtask

  task automatic rd_port_a(input logic [ADDR_W-1:0] a);
    en_a = 1'b1; we_a = 1'b0; addr_a = a; be_a = '0;
  endtask

  task automatic wr_port_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    en_b = 1'b1; we_b = 1'b1; addr_b = a; wdata_b = d; be_b = be;
  endtask

  task automatic rd_port_b(input logic [ADDR_W-1:0] a);
    en_b = 1'b1; we_b = 1'b0; addr_b = a; be_b = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_rdata_a",   rdata_a,   0);
    check("reset_rvalid_a",  rvalid_a,  0);
    check("reset_rvalid_b",  rvalid_b,  0);
    check("reset_init_done", init_done, 0);
    check("reset_coll_cnt",  coll_cnt,  0);
    $display("txn reset: init_done=%0d coll_cnt=%0d", init_done, coll_cnt);

    // Release reset; A keeps requesting reads, which must be ignored.
    rst_n = 1'b1;
    rd_port_a(4'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 16) idle();
      check("clear_rvalid_a", rvalid_a, 0);
      if (i >= 15) check($sformatf("init_done_cyc%0d", i), init_done, (i == 16) ? 1 : 0);
    end
    $display("txn clear: init_done=%0d after 16 cycles", init_done);

    // Pipelined reads of the whole cleared array.
    for (int i = 0; i < 16; i++) begin
      rd_port_a(4'(i));
      tick();
      check($sformatf("clr_rvalid_%0d", i), rvalid_a, 1);
      check($sformatf("clr_rdata_%0d", i),  rdata_a,  0);
      $display("txn read A addr=%0d rdata=%08h", i, rdata_a);
    end
    idle();
    tick();
    check("rd_end_rvalid_a", rvalid_a, 0);

    // Full write then cross-port read, both latencies.
    wr_port_a(4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    check("write_no_rvalid", rvalid_a, 0);
    $display("txn write A addr=3 data=deadbeef be=f");
    rd_port_b(4'd3);
    tick();
    idle();
    check("l1_rvalid_b",  rvalid_b,  1);
    check("l1_rdata_b",   rdata_b,   32'hDEADBEEF);
    check("l2_rvalid_b0", rvalid2_b, 0);
    $display("txn read B addr=3 rdata=%08h", rdata_b);
    tick();
    check("l1_rvalid_b_off", rvalid_b,  0);
    check("l1_rdata_hold",   rdata_b,   32'hDEADBEEF);
    check("l2_rvalid_b1",    rvalid2_b, 1);
    check("l2_rdata_b",      rdata2_b,  32'hDEADBEEF);
    tick();
    check("l2_rvalid_b_off", rvalid2_b, 0);

    // Partial byte write, then an all-zero byte-enable write.
    wr_port_a(4'd3, 32'h11223344, 4'b0101);
    tick();
    wr_port_a(4'd3, 32'hFFFFFFFF, 4'b0000);
    tick();
    rd_port_a(4'd3);
    tick();
    idle();
    check("be_partial", rdata_a, 32'hDE22BE44);
    $display("txn read A addr=3 rdata=%08h (after be=0101 and be=0)", rdata_a);

    // Same-address write collision.
    wr_port_a(4'd5, 32'hAAAAAAAA, 4'b0011);
    wr_port_b(4'd5, 32'hBBBBBBBB, 4'b1110);
    tick();
    idle();
    check("coll_cnt_1", coll_cnt, 1);
    rd_port_a(4'd5);
    tick();
    idle();
    check("coll_merge", rdata_a, 32'hBBBBAAAA);
    $display("txn collision addr=5 word=%08h coll_cnt=%0d", rdata_a, coll_cnt);
    coll_clr = 1'b1;
    tick();
    idle();
    check("coll_clr", coll_cnt, 0);

    // B with no byte enables is not a collision.
    wr_port_a(4'd5, 32'h0, 4'hF);
    wr_port_b(4'd5, 32'h0, 4'h0);
    tick();
    idle();
    check("coll_be0", coll_cnt, 0);

    // Clear wins over a coincident collision.
    wr_port_a(4'd5, 32'h1, 4'hF);
    wr_port_b(4'd5, 32'h2, 4'hF);
    tick();
    check("coll_again", coll_cnt, 1);
    coll_clr = 1'b1;
    tick();
    idle();
    check("coll_clr_wins", coll_cnt, 0);

    // Saturation after 256 collisions.
    wr_port_a(4'd6, 32'h1, 4'hF);
    wr_port_b(4'd6, 32'h2, 4'hF);
    for (int i = 0; i < 256; i++) tick();
    idle();
    check("coll_saturate", coll_cnt, 8'hFF);
    $display("txn 256 collisions coll_cnt=%0d", coll_cnt);
    coll_clr = 1'b1;
    tick();
    idle();

    // Read-first across ports.
    wr_port_a(4'd7, 32'h12345678, 4'hF);
    tick();
    wr_port_a(4'd7, 32'hCAFEF00D, 4'hF);
    rd_port_b(4'd7);
    tick();
    idle();
    check("rf_old_data", rdata_b, 32'h12345678);
    $display("txn A write + B read addr=7 rdata_b=%08h", rdata_b);
    rd_port_b(4'd7);
    tick();
    idle();
    check("rf_new_data", rdata_b, 32'hCAFEF00D);

    // Both ports read the same word.
    rd_port_a(4'd7);
    rd_port_b(4'd7);
    tick();
    idle();
    check("dual_rd_a", rdata_a, 32'hCAFEF00D);
    check("dual_rd_b", rdata_b, 32'hCAFEF00D);
    $display("txn dual read addr=7 a=%08h b=%08h", rdata_a, rdata_b);

    // Back-to-back reads, then reset with a read still in the latency-2 pipe.
    wr_port_a(4'd3, 32'hDEADBEEF, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_port_a(4'd3);
      tick();
      check($sformatf("b2b_rvalid_%0d", i), rvalid_a, 1);
      check($sformatf("b2b_rdata_%0d", i),  rdata_a,  32'hDEADBEEF);
    end
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_rvalid_a",    rvalid_a,   0);
    check("rst_rvalid2_a",   rvalid2_a,  0);
    check("rst_init_done",   init_done,  0);
    $display("txn async reset mid-read rvalid_a=%0d", rvalid_a);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("rerun_rvalid_a",  rvalid_a,  0);
      check("rerun_rvalid2_a", rvalid2_a, 0);
      if (i >= 15) check($sformatf("rerun_init_cyc%0d", i), init_done, (i == 16) ? 1 : 0);
    end
    rd_port_a(4'd3);
    tick();
    idle();
    check("rerun_rvalid", rvalid_a, 1);
    check("rerun_cleared", rdata_a, 0);
    $display("txn read A addr=3 after re-clear rdata=%08h", rdata_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
